// File: rtl/sort_sensor_frontend.sv
// sort_sensor_frontend: synchronise/debounce three item sensors and time each item.
// `SORT_ITEM_COUNT_EN adds saturating per-type item counters.
module sort_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       raw_bowl,
    input  logic       raw_chopstick,
    input  logic       raw_plate,
    output logic       detect_bowl,
    output logic       detect_chopstick,
    output logic       detect_plate,
    output logic       timeout,
    output logic       busy,
    output logic       conflict,
    output logic [7:0] cnt_bowl,
    output logic [7:0] cnt_chopstick,
    output logic [7:0] cnt_plate
);
    typedef enum logic [1:0] {
        IDLE,
        DETECT,
        TIMEOUT,
        WAIT_CLEAR
    } state_t;

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] level;
    logic [7:0] db_cnt [3];
    logic       multi;

    state_t     state;
    state_t     state_nx;
    logic [2:0] item;
    logic [2:0] item_nx;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nx;
    logic       conflict_nx;

    assign raw = {raw_plate, raw_chopstick, raw_bowl};
    // clearing the lowest set bit leaves something only if two or more are set
    assign multi = (level & (level - 3'd1)) != 3'd0;
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            level <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= 8'd0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= 8'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= 8'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx    = state;
        item_nx     = item;
        hold_nx     = hold_cnt;
        conflict_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && level != 3'b000) begin
                    if (multi) begin
                        conflict_nx = 1'b1;
                        state_nx    = WAIT_CLEAR;
                    end else begin
                        item_nx  = level;
                        hold_nx  = 8'd0;
                        state_nx = DETECT;
                    end
                end
            end
            DETECT: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = TIMEOUT;
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            TIMEOUT: state_nx = WAIT_CLEAR;
            WAIT_CLEAR: begin
                if (level == 3'b000) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // outputs are registered from the current state, one cycle behind it
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            item             <= 3'b000;
            hold_cnt         <= 8'd0;
            detect_bowl      <= 1'b0;
            detect_chopstick <= 1'b0;
            detect_plate     <= 1'b0;
            timeout          <= 1'b0;
            conflict         <= 1'b0;
        end else begin
            state    <= state_nx;
            item     <= item_nx;
            hold_cnt <= hold_nx;
            {detect_plate, detect_chopstick, detect_bowl} <=
                (state == DETECT) ? item : 3'b000;
            timeout  <= state == TIMEOUT;
            conflict <= conflict_nx;
        end
    end

`ifdef SORT_ITEM_COUNT_EN
    logic [7:0] cnt [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= 8'd0;
            end
        end else if (state == TIMEOUT) begin
            for (int i = 0; i < 3; i++) begin
                if (item[i] && cnt[i] != 8'hFF) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign cnt_bowl      = cnt[0];
    assign cnt_chopstick = cnt[1];
    assign cnt_plate     = cnt[2];
`else
    assign cnt_bowl      = 8'd0;
    assign cnt_chopstick = 8'd0;
    assign cnt_plate     = 8'd0;
`endif

endmodule

// File: tb/tb_sort_sensor_frontend.sv
// tb_sort_sensor_frontend: directed + random stimulus against a queue-based
// reference model of the sensor front end.
module tb_sort_sensor_frontend;
    localparam int D = 4;
    localparam int H = 8;
    localparam int PH_IDLE  = 0;
    localparam int PH_HOLD  = 1;
    localparam int PH_TO    = 2;
    localparam int PH_CLEAR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rb = 1'b0;
    logic       rc = 1'b0;
    logic       rp = 1'b0;
    logic       det_b;
    logic       det_c;
    logic       det_p;
    logic       tout;
    logic       busy;
    logic       conf;
    logic [7:0] cnt_b;
    logic [7:0] cnt_c;
    logic [7:0] cnt_p;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    sort_sensor_frontend #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .raw_bowl(rb),
        .raw_chopstick(rc),
        .raw_plate(rp),
        .detect_bowl(det_b),
        .detect_chopstick(det_c),
        .detect_plate(det_p),
        .timeout(tout),
        .busy(busy),
        .conflict(conf),
        .cnt_bowl(cnt_b),
        .cnt_chopstick(cnt_c),
        .cnt_plate(cnt_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d edge=%0d", tag, got, exp, edge_n);
        end
    endtask

    // reference model: 2-sample delay, a window of the last D seen samples,
    // and an item phase with a countdown of remaining hold cycles
    logic   p1 [3];
    logic   p2 [3];
    logic   db [3];
    logic   win [3][$];
    int     ph = PH_IDLE;
    int     typ = 0;
    int     left = 0;
    logic   e_det [3];
    logic   e_to = 1'b0;
    logic   e_conf = 1'b0;
    int     e_cnt [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            p1[i] = 1'b0;
            p2[i] = 1'b0;
            db[i] = 1'b0;
            e_det[i] = 1'b0;
            e_cnt[i] = 0;
        end
    end

    always @(posedge clk) begin
        logic raws [3];
        int   nb;
        int   one;
        bool_flip: begin end
        edge_n++;
        raws[0] = rb;
        raws[1] = rc;
        raws[2] = rp;
        if (reset) begin
            ph = PH_IDLE;
            e_to = 1'b0;
            e_conf = 1'b0;
            for (int i = 0; i < 3; i++) begin
                p1[i] = 1'b0;
                p2[i] = 1'b0;
                db[i] = 1'b0;
                win[i].delete();
                e_det[i] = 1'b0;
                e_cnt[i] = 0;
            end
        end else begin
            nb = 0;
            one = 0;
            for (int i = 0; i < 3; i++) begin
                if (db[i]) begin
                    nb++;
                    one = i;
                end
            end
            for (int i = 0; i < 3; i++) begin
                e_det[i] = (ph == PH_HOLD) && (typ == i);
            end
            e_to = ph == PH_TO;
            e_conf = (ph == PH_IDLE) && start && (nb >= 2);
`ifdef SORT_ITEM_COUNT_EN
            if (ph == PH_TO && e_cnt[typ] < 255) e_cnt[typ]++;
`endif
            case (ph)
                PH_IDLE: begin
                    if (start && nb == 1) begin
                        ph = PH_HOLD;
                        typ = one;
                        left = H;
                    end else if (start && nb >= 2) begin
                        ph = PH_CLEAR;
                    end
                end
                PH_HOLD: begin
                    left--;
                    if (left == 0) ph = PH_TO;
                end
                PH_TO: ph = PH_CLEAR;
                default: if (nb == 0) ph = PH_IDLE;
            endcase
            for (int i = 0; i < 3; i++) begin
                bit all_diff;
                win[i].push_back(p2[i]);
                if (win[i].size() > D) void'(win[i].pop_front());
                all_diff = win[i].size() == D;
                foreach (win[i][k]) begin
                    if (win[i][k] == db[i]) all_diff = 1'b0;
                end
                if (all_diff) db[i] = ~db[i];
                p2[i] = p1[i];
                p1[i] = raws[i];
            end
        end
    end

    task automatic compare_all();
        check("det_bowl", 32'(det_b), 32'(e_det[0]));
        check("det_chop", 32'(det_c), 32'(e_det[1]));
        check("det_plate", 32'(det_p), 32'(e_det[2]));
        check("timeout", 32'(tout), 32'(e_to));
        check("conflict", 32'(conf), 32'(e_conf));
        check("busy", 32'(busy), 32'(ph != PH_IDLE));
        check("cnt_bowl", 32'(cnt_b), 32'(e_cnt[0]));
        check("cnt_chop", 32'(cnt_c), 32'(e_cnt[1]));
        check("cnt_plate", 32'(cnt_p), 32'(e_cnt[2]));
        check("one_hot", 32'(int'(det_b) + int'(det_c) + int'(det_p) + int'(tout) <= 1), 32'd1);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    initial begin
        int seen;
        int pulses;
        int dur [3];

        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_det", 32'({det_b, det_c, det_p, tout, conf}), 32'd0);

        // single bowl: edge N is the first edge sampling raw_bowl high
        start = 1'b1;
        rb = 1'b1;
        cyc(1);
        for (int k = 1; k <= 18; k++) begin
            cyc(1);
            check("bowl_det", 32'(det_b), 32'(k >= 7 && k <= 14));
            check("bowl_to", 32'(tout), 32'(k == 15));
        end
        rb = 1'b0;
        cyc(12);
        check("bowl_idle", 32'(busy), 32'd0);
`ifdef SORT_ITEM_COUNT_EN
        check("bowl_cnt", 32'(cnt_b), 32'd1);
`endif

        // glitch shorter than the debounce window
        seen = 0;
        rp = 1'b1;
        repeat (3) begin
            cyc(1);
            seen += int'(det_p) + int'(tout) + int'(busy);
        end
        rp = 1'b0;
        repeat (15) begin
            cyc(1);
            seen += int'(det_p) + int'(tout) + int'(busy);
        end
        check("glitch_quiet", 32'(seen), 32'd0);

        // simultaneous bowl and chopstick
        pulses = 0;
        seen = 0;
        rb = 1'b1;
        rc = 1'b1;
        repeat (20) begin
            cyc(1);
            pulses += int'(conf);
            seen += int'(det_b) + int'(det_c) + int'(tout);
        end
        check("conf_pulses", 32'(pulses), 32'd1);
        check("conf_no_det", 32'(seen), 32'd0);
        check("conf_wait", 32'(busy), 32'd1);
        rb = 1'b0;
        rc = 1'b0;
        cyc(12);
        check("conf_clear", 32'(busy), 32'd0);

        // start gating
        start = 1'b0;
        rc = 1'b1;
        seen = 0;
        repeat (20) begin
            cyc(1);
            seen += int'(det_c) + int'(busy);
        end
        check("gate_quiet", 32'(seen), 32'd0);
        start = 1'b1;
        cyc(1);
        check("gate_accept", 32'(busy), 32'd1);
        cyc(1);
        check("gate_det", 32'(det_c), 32'd1);
        rc = 1'b0;
        cyc(25);

        // reset in the middle of an item
        rb = 1'b1;
        cyc(10);
        check("mid_det", 32'(det_b), 32'd1);
        reset = 1'b1;
        rb = 1'b0;
        cyc(1);
        check("mid_rst", 32'({det_b, det_c, det_p, tout, busy, conf}), 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            cyc(1);
            seen += int'(tout);
        end
        check("mid_no_to", 32'(seen), 32'd0);

        // random traffic
        for (int i = 0; i < 3; i++) dur[i] = 1;
        repeat (3000) begin
            cyc(1);
            for (int i = 0; i < 3; i++) begin
                dur[i]--;
                if (dur[i] == 0) begin
                    logic v;
                    v = ($urandom_range(0, 2) == 0);
                    dur[i] = $urandom_range(1, 14);
                    if (i == 0) rb = v;
                    else if (i == 1) rc = v;
                    else rp = v;
                end
            end
            start = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        rb = 1'b0;
        rc = 1'b0;
        rp = 1'b0;
        start = 1'b1;
        cyc(30);

`ifdef SORT_ITEM_COUNT_EN
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        repeat (260) begin
            rp = 1'b1;
            cyc(17);
            rp = 1'b0;
            cyc(9);
        end
        check("sat_plate", 32'(cnt_p), 32'd255);
        check("sat_bowl", 32'(cnt_b), 32'd0);
        check("sat_chop", 32'(cnt_c), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
